freq_gen_module: RTL and testbench



---
 rtl/freq_gen_module.sv | 177 +++++++++++++++++
 tb/tb_freq_gen_module.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/freq_gen_module.sv
// Phase-accumulator square-wave generator with glitch-free retune/stop at toggle boundaries.
// Optional once-per-window tick and rising-edge counter enabled by FREQ_GEN_SEC_TICK_EN.
module freq_gen_module #(
  parameter int unsigned FREQ_BASE = 200_000_000,
  parameter int unsigned WIDTH     = 32
) (
  input  logic             clk_base,
  input  logic             sclr,
  input  logic [WIDTH-1:0] freq_set,
  input  logic             freq_load,
  output logic             ready,
  output logic             clk_out,
  output logic             active,
  output logic             clamp
`ifdef FREQ_GEN_SEC_TICK_EN
  ,
  output logic             sec_tick,
  output logic [WIDTH-1:0] rise_cnt
`endif
);

  localparam int unsigned     FreqMax  = FREQ_BASE / 4;
  localparam int unsigned     AccW     = WIDTH + 2;
  localparam logic [AccW-1:0] BaseAcc  = AccW'(FREQ_BASE);
  localparam logic [WIDTH-1:0] FreqMaxW = WIDTH'(FreqMax);

  typedef enum logic [1:0] {StIdle, StRun, StPend} state_e;

  state_e           state_q, state_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic [AccW-1:0]  inc_q, inc_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             clamp_q, clamp_d;
  logic             active_q;

  logic             over_max;
  logic [WIDTH-1:0] f_eff;
  logic [AccW-1:0]  sum;
  logic             wrap;
  logic             accept;

  assign over_max = freq_set > FreqMaxW;
  assign f_eff    = over_max ? FreqMaxW : freq_set;
  // acc < FREQ_BASE and inc <= FREQ_BASE/2, so two extra bits rule out overflow.
  assign sum      = acc_q + inc_q;
  assign wrap     = sum >= BaseAcc;
  assign ready    = (state_q != StPend);
  assign accept   = freq_load && ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    inc_d   = inc_q;
    pend_d  = pend_q;
    clk_d   = clk_q;
    clamp_d = clamp_q;

    if (accept) begin
      clamp_d = over_max;
    end

    if (state_q != StIdle) begin
      acc_d = wrap ? (sum - BaseAcc) : sum;
      if (wrap) begin
        clk_d = ~clk_q;
      end
    end

    unique case (state_q)
      StIdle: begin
        clk_d = 1'b0;
        if (accept && (f_eff != '0)) begin
          state_d = StRun;
          inc_d   = {1'b0, f_eff, 1'b0};
          acc_d   = '0;
        end
      end
      StRun: begin
        if (accept) begin
          if ((f_eff == '0) && !clk_q) begin
            // Output already low: stop now and suppress any toggle due this cycle.
            state_d = StIdle;
            clk_d   = 1'b0;
            acc_d   = '0;
            inc_d   = '0;
          end else begin
            pend_d  = f_eff;
            state_d = StPend;
          end
        end
      end
      StPend: begin
        if ((pend_q == '0) && !clk_q) begin
          state_d = StIdle;
          clk_d   = 1'b0;
          acc_d   = '0;
          inc_d   = '0;
        end else if (wrap) begin
          if (pend_q != '0) begin
            inc_d   = {1'b0, pend_q, 1'b0};
            state_d = StRun;
          end else begin
            // Stop on the falling toggle; the rising one keeps us waiting here.
            state_d = StIdle;
            acc_d   = '0;
            inc_d   = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        clk_d   = 1'b0;
        acc_d   = '0;
        inc_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_base) begin
    if (sclr) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      inc_q    <= '0;
      pend_q   <= '0;
      clk_q    <= 1'b0;
      clamp_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      inc_q    <= inc_d;
      pend_q   <= pend_d;
      clk_q    <= clk_d;
      clamp_q  <= clamp_d;
      active_q <= (state_d != StIdle);
    end
  end

  assign clk_out = clk_q;
  assign active  = active_q;
  assign clamp   = clamp_q;

`ifdef FREQ_GEN_SEC_TICK_EN
  localparam int unsigned WcntW = (FREQ_BASE > 1) ? $clog2(FREQ_BASE) : 1;

  logic [WcntW-1:0] wcnt_q;
  logic [WIDTH-1:0] ecnt_q;
  logic [WIDTH-1:0] rise_cnt_q;
  logic             wcnt_last;
  logic             rise_evt;
  logic [WIDTH-1:0] ecnt_next;

  assign wcnt_last = (wcnt_q == WcntW'(FREQ_BASE - 1));
  assign rise_evt  = clk_d && !clk_q;
  assign ecnt_next = ecnt_q + WIDTH'(rise_evt);

  always_ff @(posedge clk_base) begin
    if (sclr) begin
      wcnt_q     <= '0;
      ecnt_q     <= '0;
      rise_cnt_q <= '0;
    end else if (wcnt_last) begin
      wcnt_q     <= '0;
      ecnt_q     <= '0;
      rise_cnt_q <= ecnt_next;
    end else begin
      wcnt_q     <= wcnt_q + 1'b1;
      ecnt_q     <= ecnt_next;
    end
  end

  assign sec_tick = wcnt_last;
  assign rise_cnt = rise_cnt_q;
`endif

endmodule

// File: tb/tb_freq_gen_module.sv
// Directed self-checking bench for freq_gen_module with FREQ_BASE = 100.
module tb_freq_gen_module;

  localparam int unsigned Base = 100;

  logic        clk_base = 1'b0;
  logic        sclr = 1'b1;
  logic [31:0] freq_set = '0;
  logic        freq_load = 1'b0;
  logic        ready;
  logic        clk_out;
  logic        active;
  logic        clamp;
`ifdef FREQ_GEN_SEC_TICK_EN
  logic        sec_tick;
  logic [31:0] rise_cnt;
`endif

  int checks = 0;
  int failures = 0;

  freq_gen_module #(
    .FREQ_BASE(Base),
    .WIDTH    (32)
  ) dut (
    .clk_base (clk_base),
    .sclr     (sclr),
    .freq_set (freq_set),
    .freq_load(freq_load),
    .ready    (ready),
    .clk_out  (clk_out),
    .active   (active),
    .clamp    (clamp)
`ifdef FREQ_GEN_SEC_TICK_EN
    ,
    .sec_tick (sec_tick),
    .rise_cnt (rise_cnt)
`endif
  );

  always #5 clk_base = ~clk_base;

  task automatic tick();
    @(posedge clk_base);
    #1;
  endtask

  task automatic do_reset();
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] v);
    freq_set  = v;
    freq_load = 1'b1;
    tick();
    freq_load = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL reset_clk_out got=%b want=0", clk_out); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", ready); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b want=0", active); end
    checks++; if (clamp !== 1'b0) begin failures++; $display("FAIL reset_clamp got=%b want=0", clamp); end
`ifdef FREQ_GEN_SEC_TICK_EN
    checks++; if (sec_tick !== 1'b0) begin failures++; $display("FAIL reset_sec_tick got=%b want=0", sec_tick); end
    checks++; if (rise_cnt !== 32'd0) begin failures++; $display("FAIL reset_rise_cnt got=%0d want=0", rise_cnt); end
`endif
  endtask

  task automatic test_start_25();
    logic exp;
    do_reset();
    do_load(32'd25);
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL start25_active got=%b want=1", active); end
    checks++; if (clamp !== 1'b0) begin failures++; $display("FAIL start25_clamp got=%b want=0", clamp); end
    checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL start25_clk0 got=%b want=0", clk_out); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL start25_ready got=%b want=1", ready); end
    // inc=50: rises 2 cycles into RUN, then toggles every 2 cycles.
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp = ((k / 2) % 2) == 1;
      checks++;
      if (clk_out !== exp) begin
        failures++; $display("FAIL start25_wave k=%0d got=%b want=%b", k, clk_out, exp);
      end
    end
  endtask

  task automatic test_clamp_retune();
    logic exp;
    do_reset();
    do_load(32'd30);
    checks++; if (clamp !== 1'b1) begin failures++; $display("FAIL clamp30_clamp got=%b want=1", clamp); end
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL clamp30_active got=%b want=1", active); end
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp = ((k / 2) % 2) == 1;
      checks++;
      if (clk_out !== exp) begin
        failures++; $display("FAIL clamp30_wave k=%0d got=%b want=%b", k, clk_out, exp);
      end
    end
    do_load(32'd10);
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL retune_ready got=%b want=0", ready); end
    checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL retune_hold got=%b want=0", clk_out); end
    checks++; if (clamp !== 1'b0) begin failures++; $display("FAIL retune_clamp got=%b want=0", clamp); end
    // Load while ready=0 must be dropped; 40 would set clamp if accepted.
    freq_set  = 32'd40;
    freq_load = 1'b1;
    tick();
    freq_load = 1'b0;
    checks++; if (clk_out !== 1'b1) begin failures++; $display("FAIL retune_toggle got=%b want=1", clk_out); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL retune_ready2 got=%b want=1", ready); end
    checks++; if (clamp !== 1'b0) begin failures++; $display("FAIL ignored_load_clamp got=%b want=0", clamp); end
    for (int m = 1; m <= 20; m++) begin
      tick();
      exp = ((m / 5) % 2) == 0;
      checks++;
      if (clk_out !== exp) begin
        failures++; $display("FAIL retune10_wave m=%0d got=%b want=%b", m, clk_out, exp);
      end
    end
  endtask

  task automatic test_stop();
    int bad;
    // Continues from 10 Hz with clk_out just risen.
    do_load(32'd0);
    checks++; if (clk_out !== 1'b1) begin failures++; $display("FAIL stop_hold got=%b want=1", clk_out); end
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL stop_active_pend got=%b want=1", active); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL stop_ready_pend got=%b want=0", ready); end
    for (int m = 22; m <= 24; m++) begin
      tick();
      checks++;
      if ((clk_out !== 1'b1) || (active !== 1'b1)) begin
        failures++; $display("FAIL stop_wait m=%0d got=%b%b want=11", m, clk_out, active);
      end
    end
    tick();
    checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL stop_fall got=%b want=0", clk_out); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL stop_idle got=%b want=0", active); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL stop_ready got=%b want=1", ready); end
    bad = 0;
    repeat (20) begin
      tick();
      if ((clk_out !== 1'b0) || (active !== 1'b0)) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL stop_quiet got=%0d want=0", bad); end
  endtask

  task automatic test_window_3();
    logic prev;
    int   cnt;
`ifdef FREQ_GEN_SEC_TICK_EN
    int   sec_seen;
    logic chk_pend;
    sec_seen = 0;
    chk_pend = 1'b0;
`endif
    do_reset();
    do_load(32'd3);
    repeat (50) tick();
    prev = clk_out;
    for (int w = 0; w < 3; w++) begin
      cnt = 0;
      for (int i = 0; i < int'(Base); i++) begin
        tick();
        if (clk_out && !prev) cnt++;
        prev = clk_out;
`ifdef FREQ_GEN_SEC_TICK_EN
        if (chk_pend) begin
          chk_pend = 1'b0;
          checks++;
          if (rise_cnt !== 32'd3) begin
            failures++; $display("FAIL rise_cnt got=%0d want=3", rise_cnt);
          end
        end
        if (sec_tick === 1'b1) begin
          sec_seen++;
          if (sec_seen >= 2) chk_pend = 1'b1;
        end
`endif
      end
      checks++;
      if (cnt != 3) begin
        failures++; $display("FAIL window3 w=%0d got=%0d want=3", w, cnt);
      end
    end
`ifdef FREQ_GEN_SEC_TICK_EN
    checks++; if (sec_seen != 3) begin failures++; $display("FAIL sec_tick_count got=%0d want=3", sec_seen); end
`endif
  endtask

  task automatic test_sclr_abort();
    int bad;
    do_reset();
    do_load(32'd25);
    tick();
    tick();
    checks++; if (clk_out !== 1'b1) begin failures++; $display("FAIL abort_pre got=%b want=1", clk_out); end
    sclr      = 1'b1;
    freq_set  = 32'd30;
    freq_load = 1'b1;
    tick();
    sclr      = 1'b0;
    freq_load = 1'b0;
    checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL abort_clk got=%b want=0", clk_out); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL abort_active got=%b want=0", active); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b want=1", ready); end
    checks++; if (clamp !== 1'b0) begin failures++; $display("FAIL abort_clamp got=%b want=0", clamp); end
    bad = 0;
    repeat (5) begin
      tick();
      if ((clk_out !== 1'b0) || (active !== 1'b0)) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL abort_quiet got=%0d want=0", bad); end
    do_load(32'd0);
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL idle_zero_active got=%b want=0", active); end
  endtask

  initial begin
    test_reset();
    test_start_25();
    test_clamp_retune();
    test_stop();
    test_window_3();
    test_sclr_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
